// File: rtl/tpu_pkg.sv
// Shared types and address map for the TPU job sequencer and its core port.
package tpu_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_LOAD_C = 3'd3,
        S_ZERO_C = 3'd4,
        S_START  = 3'd5,
        S_WAIT   = 3'd6,
        S_READ_C = 3'd7
    } tpu_seq_state_t;

    localparam logic [15:0] TPU_A_BASE  = 16'h0100;
    localparam logic [15:0] TPU_B_BASE  = 16'h0200;
    localparam logic [15:0] TPU_C_BASE  = 16'h0300;
    localparam logic [15:0] TPU_MM_ADDR = 16'h0400;

endpackage

// File: rtl/tpu_job_seq_if.sv
// Host stream in, result stream out, and the memory-mapped TPU core port.
// Valid/ready: a word moves on a rising edge where valid & ready are both high;
// the producer holds data stable while valid is high and ready is low.
interface tpu_job_seq_if #(
    parameter int DATAW = 64,
    parameter int ADDRW = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [DATAW-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [DATAW-1:0] out_data;
    logic             out_last;
    logic             tpu_r_w;
    logic [ADDRW-1:0] tpu_addr;
    logic [DATAW-1:0] tpu_dataIn;
    logic [DATAW-1:0] tpu_dataOut;

    // master: host/core side; slave: the sequencer
    modport master (
        output in_valid, in_data, out_ready, tpu_dataOut,
        input  in_ready, out_valid, out_data, out_last, tpu_r_w, tpu_addr, tpu_dataIn
    );
    modport slave (
        input  in_valid, in_data, out_ready, tpu_dataOut,
        output in_ready, out_valid, out_data, out_last, tpu_r_w, tpu_addr, tpu_dataIn
    );
endinterface

// File: rtl/tpu_out_reg.sv
// One-entry valid/ready output register for result words; holds while stalled.
module tpu_out_reg #(
    parameter int DATAW = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DATAW-1:0] load_data,
    input  logic             load_last,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [DATAW-1:0] out_data,
    output logic             out_last
);
    // load is only raised when the entry is empty or draining this cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_last  <= load_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/tpu_job_seq.sv
// Job sequencer: streams A/B/C into the TPU core, triggers the matmul,
// waits out the compute window and streams the C result back out.
module tpu_job_seq
    import tpu_pkg::*;
#(
    parameter int DIM       = 8,
    parameter int BITS_AB   = 8,
    parameter int BITS_C    = 16,
    parameter int ADDRW     = 16,
    parameter int DATAW     = 64,
    parameter int MM_CYCLES = DIM * 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cfg_zero_c,
    output logic           busy,
    output logic           done,
    output tpu_seq_state_t dbg_state,
    tpu_job_seq_if.slave   bus
);
    localparam int NWORDS = 2 * DIM;
    localparam int IDXW   = $clog2(NWORDS) + 1;
    localparam int WCW    = (MM_CYCLES > 1) ? $clog2(MM_CYCLES) : 1;

    if (DATAW != DIM * BITS_AB || 2 * DATAW != DIM * BITS_C) begin : g_bad_width
        $error("tpu_job_seq: DATAW must equal DIM*BITS_AB and DIM*BITS_C/2");
    end

    tpu_seq_state_t   state;
    logic [IDXW-1:0]  idx;
    logic [WCW-1:0]   wait_cnt;
    logic             zero_c_q;
    logic             in_fire;
    logic             load_out;
    logic             last_word;
    logic             last_fire;
    logic [ADDRW-1:0] word_off;

    assign dbg_state = state;
    assign busy      = (state != S_IDLE);
    assign in_fire   = bus.in_valid & bus.in_ready;
    assign last_word = (idx == IDXW'(NWORDS - 1));
    assign last_fire = bus.out_valid & bus.out_ready & bus.out_last;
    // every region is laid out as consecutive 8-byte words, so C word k = row k>>1, half k&1
    assign word_off  = ADDRW'(idx) << 3;

    always_comb begin
        bus.in_ready = (state == S_LOAD_A) || (state == S_LOAD_B) || (state == S_LOAD_C);
        load_out     = (state == S_READ_C) && (!bus.out_valid || bus.out_ready) &&
                       (idx < IDXW'(NWORDS));
    end

    // Core port is combinational so each accepted word lands on the very next edge.
    always_comb begin
        bus.tpu_r_w    = 1'b0;
        bus.tpu_addr   = '0;
        bus.tpu_dataIn = '0;
        case (state)
            S_LOAD_A: if (in_fire) begin
                bus.tpu_r_w    = 1'b1;
                bus.tpu_addr   = ADDRW'(TPU_A_BASE) + word_off;
                bus.tpu_dataIn = bus.in_data;
            end
            S_LOAD_B: if (in_fire) begin
                bus.tpu_r_w    = 1'b1;
                bus.tpu_addr   = ADDRW'(TPU_B_BASE) + word_off;
                bus.tpu_dataIn = bus.in_data;
            end
            S_LOAD_C: if (in_fire) begin
                bus.tpu_r_w    = 1'b1;
                bus.tpu_addr   = ADDRW'(TPU_C_BASE) + word_off;
                bus.tpu_dataIn = bus.in_data;
            end
            S_ZERO_C: begin
                bus.tpu_r_w  = 1'b1;
                bus.tpu_addr = ADDRW'(TPU_C_BASE) + word_off;
            end
            S_START:  bus.tpu_addr = ADDRW'(TPU_MM_ADDR);
            S_READ_C: if (idx < IDXW'(NWORDS)) bus.tpu_addr = ADDRW'(TPU_C_BASE) + word_off;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            idx      <= '0;
            wait_cnt <= '0;
            zero_c_q <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (bus.in_valid) begin
                    zero_c_q <= cfg_zero_c;
                    idx      <= '0;
                    state    <= S_LOAD_A;
                end
                S_LOAD_A: if (in_fire) begin
                    if (idx == IDXW'(DIM - 1)) begin
                        idx   <= '0;
                        state <= S_LOAD_B;
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                S_LOAD_B: if (in_fire) begin
                    if (idx == IDXW'(DIM - 1)) begin
                        idx   <= '0;
                        state <= zero_c_q ? S_ZERO_C : S_LOAD_C;
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                S_LOAD_C: if (in_fire) begin
                    if (last_word) begin
                        idx   <= '0;
                        state <= S_START;
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                S_ZERO_C: begin
                    if (last_word) begin
                        idx   <= '0;
                        state <= S_START;
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                S_START: begin
                    idx      <= '0;
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == WCW'(MM_CYCLES - 1)) begin
                        idx   <= '0;
                        state <= S_READ_C;
                    end else begin
                        wait_cnt <= wait_cnt + WCW'(1);
                    end
                end
                S_READ_C: begin
                    if (last_fire) begin
                        idx   <= '0;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end else if (load_out) begin
                        idx <= idx + IDXW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    tpu_out_reg #(.DATAW(DATAW)) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load_out),
        .load_data (bus.tpu_dataOut),
        .load_last (last_word),
        .out_ready (bus.out_ready),
        .out_valid (bus.out_valid),
        .out_data  (bus.out_data),
        .out_last  (bus.out_last)
    );
endmodule

// File: tb/tb_tpu_job_seq.sv
// Bench for tpu_job_seq: behavioural TPU core, job vector table, scoreboard.
module tb_tpu_job_seq;
    import tpu_pkg::*;

    localparam int DIM = 8;
    localparam int MM  = DIM * 4;
    localparam int LAT = 2 * DIM + 2 * DIM + 1 + MM + 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           cfg_zero_c;
    logic           busy;
    logic           done;
    tpu_seq_state_t dbg_state;

    tpu_job_seq_if #(.DATAW(64), .ADDRW(16)) bus ();

    tpu_job_seq #(.DIM(DIM), .BITS_AB(8), .BITS_C(16), .ADDRW(16), .DATAW(64), .MM_CYCLES(MM)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_zero_c (cfg_zero_c),
        .busy       (busy),
        .done       (done),
        .dbg_state  (dbg_state),
        .bus        (bus)
    );

    // ---------------- clock / counters ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    int done_cnt = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    // ---------------- behavioural TPU core ----------------
    logic [63:0] a_mem [8];
    logic [63:0] b_mem [8];
    logic [63:0] c_mem [16];

    function automatic logic [63:0] core_rd(input logic [15:0] a);
        if (a >= 16'h0300 && a < 16'h0380 && a[2:0] == 3'b000) return c_mem[a[6:3]];
        return 64'h0;
    endfunction

    always_comb bus.tpu_dataOut = core_rd(bus.tpu_addr);

    always @(posedge clk) begin
        logic [63:0] tmp [16];
        logic [15:0] acc;
        if (bus.tpu_r_w) begin
            if (bus.tpu_addr[15:6] == 10'h004) a_mem[bus.tpu_addr[5:3]] = bus.tpu_dataIn;
            if (bus.tpu_addr[15:6] == 10'h008) b_mem[bus.tpu_addr[5:3]] = bus.tpu_dataIn;
            if (bus.tpu_addr[15:7] == 9'h006)  c_mem[bus.tpu_addr[6:3]] = bus.tpu_dataIn;
        end else if (bus.tpu_addr == 16'h0400) begin
            for (int i = 0; i < DIM; i++) begin
                for (int j = 0; j < DIM; j++) begin
                    acc = c_mem[2 * i + j / 4][16 * (j % 4) +: 16];
                    for (int k = 0; k < DIM; k++)
                        acc = acc + 16'(a_mem[i][8 * k +: 8]) * 16'(b_mem[k][8 * j +: 8]);
                    tmp[2 * i + j / 4][16 * (j % 4) +: 16] = acc;
                end
            end
            for (int w = 0; w < 16; w++) c_mem[w] = tmp[w];
        end
    end

    // ---------------- vectors and reference model ----------------
    typedef struct {
        bit          zero_c;
        bit          a_ramp;   // 0: every A element a_val; 1: A[i][k] = 8i+k+a_val
        logic [7:0]  a_val;
        bit          b_ones;   // 0: identity; 1: all ones
        logic [15:0] c_val;
        bit          gap;
        bit          stall;
        logic [63:0] exp_w0;   // hand-computed first result word
        logic [63:0] exp_w15;  // hand-computed last result word
    } vec_t;

    vec_t vecs [6];

    logic [63:0] in_q [$];
    logic [63:0] exp_q [$];

    int vec_cnt = 0;
    int miscmp  = 0;

    function automatic logic [7:0] a_elem(input vec_t v, input int i, input int k);
        return v.a_ramp ? 8'(8 * i + k + int'(v.a_val)) : v.a_val;
    endfunction

    function automatic logic [7:0] b_elem(input vec_t v, input int k, input int j);
        return (v.b_ones || k == j) ? 8'd1 : 8'd0;
    endfunction

    function automatic logic [15:0] exp_elem(input vec_t v, input int i, input int j);
        logic [15:0] acc;
        acc = v.zero_c ? 16'h0 : v.c_val;
        for (int k = 0; k < DIM; k++) acc = acc + 16'(a_elem(v, i, k)) * 16'(b_elem(v, k, j));
        return acc;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miscmp++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic build_queues(input vec_t v);
        logic [63:0] w;
        in_q.delete();
        exp_q.delete();
        for (int i = 0; i < DIM; i++) begin
            w = '0;
            for (int k = 0; k < DIM; k++) w[8 * k +: 8] = a_elem(v, i, k);
            in_q.push_back(w);
        end
        for (int r = 0; r < DIM; r++) begin
            w = '0;
            for (int j = 0; j < DIM; j++) w[8 * j +: 8] = b_elem(v, r, j);
            in_q.push_back(w);
        end
        if (!v.zero_c)
            for (int c = 0; c < 2 * DIM; c++) in_q.push_back({4{v.c_val}});
        for (int r = 0; r < DIM; r++) begin
            for (int h = 0; h < 2; h++) begin
                for (int e = 0; e < 4; e++) w[16 * e +: 16] = exp_elem(v, r, 4 * h + e);
                exp_q.push_back(w);
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"},      64'(busy),           64'd0);
        chk({tag, "_done"},      64'(done),           64'd0);
        chk({tag, "_in_ready"},  64'(bus.in_ready),   64'd0);
        chk({tag, "_out_valid"}, 64'(bus.out_valid),  64'd0);
        chk({tag, "_out_last"},  64'(bus.out_last),   64'd0);
        chk({tag, "_out_data"},  bus.out_data,        64'd0);
        chk({tag, "_r_w"},       64'(bus.tpu_r_w),    64'd0);
        chk({tag, "_addr"},      64'(bus.tpu_addr),   64'd0);
        chk({tag, "_data_in"},   bus.tpu_dataIn,      64'd0);
        chk({tag, "_state"},     64'(dbg_state),      64'(S_IDLE));
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_words(input bit gap, output int first_cyc);
        int  budget = 0;
        bit  tog    = 1'b0;
        bit  first  = 1'b1;
        first_cyc = 0;
        while (in_q.size() > 0 && budget < 3000) begin
            @(negedge clk);
            budget++;
            tog = gap ? ~tog : 1'b1;
            bus.in_valid = tog;
            bus.in_data  = in_q[0];
            #1;
            if (!tog && (dbg_state == S_LOAD_A || dbg_state == S_LOAD_B || dbg_state == S_LOAD_C)) begin
                chk("gap_r_w",  64'(bus.tpu_r_w),  64'd0);
                chk("gap_addr", 64'(bus.tpu_addr), 64'd0);
            end
            if (tog && bus.in_ready) begin
                chk("wr_strobe", 64'(bus.tpu_r_w), 64'd1);
                chk("wr_data",   bus.tpu_dataIn,   in_q[0]);
                if (first) begin
                    first     = 1'b0;
                    first_cyc = cyc;
                end
                void'(in_q.pop_front());
            end
        end
        if (in_q.size() > 0) begin
            vec_cnt++;
            miscmp++;
            $display("FAIL in_timeout: %0d words left unconsumed", in_q.size());
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        chk("no_extra_input", 64'(bus.in_ready), 64'd0);
    endtask

    task automatic collect(input bit stall, input logic [63:0] w0, input logic [63:0] w15,
                           output int first_cyc);
        int          got    = 0;
        int          budget = 0;
        int          hold   = 0;
        bit          seen   = 1'b0;
        logic [63:0] exp_w;
        first_cyc = 0;
        while (got < 2 * DIM && budget < 3000) begin
            @(negedge clk);
            budget++;
            if (bus.out_valid && !seen) begin
                seen      = 1'b1;
                first_cyc = cyc;
            end
            if (stall && seen && hold < 10) begin
                bus.out_ready = 1'b0;
                hold++;
                chk("stall_valid", 64'(bus.out_valid), 64'd1);
                chk("stall_data",  bus.out_data,       exp_q[0]);
            end else begin
                bus.out_ready = 1'b1;
            end
            #1;
            if (bus.out_valid && bus.out_ready) begin
                exp_w = exp_q.pop_front();
                chk("out_word", bus.out_data,      exp_w);
                chk("out_last", 64'(bus.out_last), 64'(got == 2 * DIM - 1));
                if (got == 0)           chk("hand_w0",  bus.out_data, w0);
                if (got == 2 * DIM - 1) chk("hand_w15", bus.out_data, w15);
                got++;
            end
        end
        if (got < 2 * DIM) begin
            vec_cnt++;
            miscmp++;
            $display("FAIL out_timeout: got %0d words expected %0d", got, 2 * DIM);
        end
        @(negedge clk);
        #1;
        chk("done_pulse",    64'(done),          64'd1);
        chk("busy_fall",     64'(busy),          64'd0);
        chk("no_extra_word", 64'(bus.out_valid), 64'd0);
    endtask

    task automatic run_job(input vec_t v);
        int t_in;
        int t_out;
        int d0;
        build_queues(v);
        cfg_zero_c = v.zero_c;
        d0 = done_cnt;
        fork
            drive_words(v.gap, t_in);
            collect(v.stall, v.exp_w0, v.exp_w15, t_out);
        join
        if (!v.gap) chk("latency", 64'(t_out - t_in), 64'(LAT));
        @(negedge clk);
        #1;
        chk("done_low",  64'(done),          64'd0);
        chk("done_once", 64'(done_cnt - d0), 64'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int t;
        int n;
        //           zc ramp aval   ones cval     gap stall  exp_w0                  exp_w15
        vecs[0] = '{1, 0, 8'd1, 0, 16'd0, 0, 0, 64'h0001_0001_0001_0001, 64'h0001_0001_0001_0001};
        vecs[1] = '{0, 0, 8'd1, 0, 16'd5, 0, 0, 64'h0006_0006_0006_0006, 64'h0006_0006_0006_0006};
        vecs[2] = '{1, 0, 8'd1, 0, 16'd0, 1, 0, 64'h0001_0001_0001_0001, 64'h0001_0001_0001_0001};
        vecs[3] = '{1, 1, 8'd0, 0, 16'd0, 0, 1, 64'h0003_0002_0001_0000, 64'h003F_003E_003D_003C};
        vecs[4] = '{0, 1, 8'd0, 1, 16'd3, 0, 0, 64'h001F_001F_001F_001F, 64'h01DF_01DF_01DF_01DF};
        vecs[5] = '{1, 0, 8'd2, 1, 16'd0, 0, 0, 64'h0010_0010_0010_0010, 64'h0010_0010_0010_0010};

        rst           = 1'b1;
        cfg_zero_c    = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        for (int w = 0; w < 16; w++) c_mem[w] = 64'hDEAD_BEEF_DEAD_BEEF;
        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 4; v++) run_job(vecs[v]);

        // abort a job in the compute window, then confirm a clean job follows
        build_queues(vecs[0]);
        cfg_zero_c = 1'b1;
        drive_words(1'b0, t);
        n = 0;
        while (dbg_state != S_WAIT && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("wait_reached", 64'(dbg_state), 64'(S_WAIT));
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check_idle_outputs("mid_rst");
        @(negedge clk);
        rst = 1'b0;

        run_job(vecs[4]);
        run_job(vecs[5]);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscmp);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/tpu_job_seq.md
# tpu_job_seq

Job sequencer that drives the memory-mapped port of the TPU matmul core (A/B/C memories plus the systolic array) from one host data stream. It accepts A rows, B rows and optional C preload words on a valid/ready input stream, writes them into the core, triggers the matmul, and waits out the fixed compute window. It then reads the C result back as a valid/ready output stream. It sits between the host/DMA stream logic and the TPU core, and it is the only master of the core's `r_w`, `addr` and `dataIn`.

## Interface
- `DIM`, 8: array dimension; A/B rows per job.
- `BITS_AB`, 8: A/B element width.
- `BITS_C`, 16: C element width.
- `ADDRW`, 16: core address width.
- `DATAW`, 64: stream and core data width. Must equal `DIM*BITS_AB` and `DIM*BITS_C/2`.
- `MM_CYCLES`, `DIM*4`: wait cycles after the matmul trigger.

Clocking and reset: one clock; reset is asynchronous and active-high.

- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `cfg_zero_c` in 1: sampled when a job starts. 1 means C is zero-filled internally and no C words are consumed.
- `in_valid` in 1: input word valid.
- `in_ready` out 1: input word accepted when `in_valid & in_ready`.
- `in_data` in DATAW: A row, B row, or C half-row.
- `out_valid` out 1: result word valid.
- `out_ready` in 1: consumer accepts the word.
- `out_data` out DATAW: C half-row; low half (elements 0..DIM/2-1) first.
- `out_last` out 1: marks the final result word of a job.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last result word is accepted.
- `tpu_r_w` out 1: core write strobe (1 = write).
- `tpu_addr` out ADDRW: core address.
- `tpu_dataIn` out DATAW: core write data.
- `tpu_dataOut` in DATAW: core read data, combinational from `tpu_addr`.

## Operation
Address map, with `r` = row and `h` = half:
- A row r: `0x100 + 8r`.
- B row r: `0x200 + 8r`. B is shifted in, so rows are sent in order 0..DIM-1.
- C half: `0x300 + 16r + 8h`.
- Matmul trigger: `0x400`.

States:
- **IDLE**: `in_ready`=0. When `in_valid`=1, latch `cfg_zero_c` and go to LOAD_A. The word is not consumed in this cycle.
- **LOAD_A**: `in_ready`=1. Each handshake drives `tpu_r_w`=1, `tpu_addr`=A row `idx`, `tpu_dataIn`=`in_data`, then `idx++`. After DIM handshakes, go to LOAD_B.
- **LOAD_B**: same as LOAD_A with B addresses. After DIM handshakes, go to ZERO_C if the latched `cfg_zero_c` is 1, otherwise LOAD_C.
- **LOAD_C**: consumes 2*DIM words. Word k goes to row k>>1, half k&1.
- **ZERO_C**: `in_ready`=0. Performs 2*DIM writes of 0, one per cycle, then goes to START.
- **START**: one cycle with `tpu_addr`=0x400 and `tpu_r_w`=0, then go to WAIT.
- **WAIT**: MM_CYCLES cycles, then go to READ_C.
- **READ_C**: `tpu_r_w`=0. `tpu_addr` = C address of word `idx`. Whenever the output register is free (`!out_valid || out_ready`) and `idx` < 2*DIM, capture `tpu_dataOut` into `out_data`, set `out_valid`, set `out_last` = (`idx`==2*DIM-1), and `idx++`. When the last word handshakes, pulse `done` and go to IDLE.

Rules that apply in every state:
- When no write is being issued, `tpu_r_w`=0, `tpu_addr`=0 and `tpu_dataIn`=0. During a load stall (`in_valid`=0), `tpu_r_w`=0 and `tpu_addr`=0.
- `idx` is $clog2(2*DIM)+1 bits. It clears on every state change.

## Timing
- Reset values: state=IDLE, `idx`=0, `in_ready`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `done`=0, `busy`=0, `tpu_r_w`=0, `tpu_addr`=0, `tpu_dataIn`=0. Reset mid-job aborts immediately; no partial output is emitted. The core's own reset is `~rst` at integration.
- Core write signals are combinational from state, `idx` and the input handshake, and take effect at the next clock edge. There is zero added latency per load word, so a full-rate stream loads in exactly 2*DIM (+2*DIM) cycles.
- Minimum job latency from the first load handshake to the first `out_valid`: 2*DIM + C phase + 1 (START) + MM_CYCLES + 1 cycles.
- Output backpressure: `out_data`, `out_valid` and `out_last` hold stable while `out_valid & !out_ready`. With `out_ready` held at 1, the result rate is one word per cycle.
- `done` asserts in the cycle after the final handshake. `busy` falls in the same cycle.
- `in_valid` in IDLE while `busy` is low starts the next job on the following cycle. Back-to-back jobs are allowed.

## Structure
- Shared package `tpu_pkg`:
  - state enum `tpu_seq_state_t`;
  - region base constants `TPU_A_BASE`, `TPU_B_BASE`, `TPU_C_BASE`, `TPU_MM_ADDR`.
- One sub-module, `tpu_out_reg`: a one-entry valid/ready skid register holding `out_data` and `out_last`.

## Test plan
- Reset with `cfg_zero_c`=1: stream 8 A rows of 0x0101…01, then 8 B rows equal to identity → output is 16 words. Each C element equals 1 for identity-masked positions; `out_last` is high only on word 15; `done` pulses once.
- `cfg_zero_c`=0 with C preload of all 0x0005: same A/B → every output element is the previous result + 5. The input consumes exactly 32 words.
- Input gaps (`in_valid` toggling every other cycle) during LOAD_A/B → the core sees no writes on gap cycles (`tpu_r_w`=0, `tpu_addr`=0); results are identical to the full-rate run.
- `out_ready` held low for 10 cycles after the first `out_valid` → `out_data` holds word 0 stable; no word is lost or duplicated; 16 words total.
- Assert `rst` during WAIT → all outputs return to reset values next cycle. A following full job completes correctly.
- Two jobs back-to-back with different A → `done` pulses twice. Each 16-word output matches its own reference model.
